// File: rtl/gate_tester_pkg.sv
// Shared definitions for the primitive-gate exerciser: FSM state encodings and
// the GATE_OP function codes understood by gate_ref_model.
package gate_tester_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SETTLE = 2'd1;
  localparam state_t SAMPLE = 2'd2;
  localparam state_t DONE   = 2'd3;

  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_NAND = 2;
  localparam int OP_NOR  = 3;
  localparam int OP_XOR  = 4;
  localparam int OP_XNOR = 5;

  function automatic logic op_legal(input int op);
    return (op >= OP_AND) && (op <= OP_XNOR);
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for a primitive gate: reduction of every stim bit
// according to GATE_OP. Reusable by any bench that needs the golden output.
module gate_ref_model
  import gate_tester_pkg::*;
#(
  parameter int N_INPUTS = 2,
  parameter int GATE_OP  = 0
) (
  input  logic [N_INPUTS-1:0] stim,
  output logic                exp_y
);

  if (!op_legal(GATE_OP)) begin : g_bad_op
    $error("gate_ref_model: illegal GATE_OP %0d", GATE_OP);
  end

  always_comb begin
    case (GATE_OP)
      OP_AND:  exp_y = &stim;
      OP_OR:   exp_y = |stim;
      OP_NAND: exp_y = ~&stim;
      OP_NOR:  exp_y = ~|stim;
      OP_XOR:  exp_y = ^stim;
      OP_XNOR: exp_y = ~^stim;
      default: exp_y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_tester.sv
// Exhaustive sweep driver/checker for a primitive gate: walks stim through all
// input combinations, samples dut_y after a settle window and tallies mismatches.
module gate_tester
  import gate_tester_pkg::*;
#(
  parameter int N_INPUTS      = 2,
  parameter int GATE_OP       = 0,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [N_INPUTS-1:0] stim,
  input  logic                dut_y,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   err_count,
  output logic                fail_valid,
  output logic [N_INPUTS-1:0] first_fail
);

  if (N_INPUTS < 1 || N_INPUTS > 8) begin : g_bad_width
    $error("gate_tester: N_INPUTS %0d outside 1..8", N_INPUTS);
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("gate_tester: SETTLE_CYCLES %0d outside 1..15", SETTLE_CYCLES);
  end

  localparam logic [3:0]          SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] STIM_LAST   = '1;
  localparam logic [N_INPUTS-1:0] STIM_ONE    = N_INPUTS'(1);

  state_t              r_state;
  logic [3:0]          r_settle_cnt;
  logic [N_INPUTS-1:0] r_stim;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [N_INPUTS:0]   r_err_count;
  logic                r_fail_valid;
  logic [N_INPUTS-1:0] r_first_fail;

  logic                w_exp_y;
  logic                w_mismatch;
  logic [N_INPUTS:0]   w_err_next;

  gate_ref_model #(
    .N_INPUTS (N_INPUTS),
    .GATE_OP  (GATE_OP)
  ) u_ref (
    .stim  (r_stim),
    .exp_y (w_exp_y)
  );

  // X-pessimistic: an unknown gate output never counts as a match.
  assign w_mismatch = (dut_y !== w_exp_y);
  assign w_err_next = r_err_count + (N_INPUTS + 1)'(w_mismatch);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_settle_cnt <= 4'd0;
      r_stim       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state      <= SETTLE;
            r_settle_cnt <= 4'd0;
            r_stim       <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_first_fail <= '0;
          end
        end
        SETTLE: begin
          r_settle_cnt <= r_settle_cnt + 4'd1;
          if (r_settle_cnt == SETTLE_LAST) begin
            r_state <= SAMPLE;
          end
        end
        SAMPLE: begin
          r_err_count <= w_err_next;
          if (w_mismatch && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_first_fail <= r_stim;
          end
          // Last vector is caught here so stim never wraps past all-ones.
          if (r_stim == STIM_LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_state      <= SETTLE;
            r_stim       <= r_stim + STIM_ONE;
            r_settle_cnt <= 4'd0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign stim       = r_stim;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err_count;
  assign fail_valid = r_fail_valid;
  assign first_fail = r_first_fail;

endmodule
